// File: rtl/score_display_pkg.sv
// -----------------------------------------------------------------------------
// score_display_pkg
// Shared types and constants for the score display scanner.
//   - Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - Anode "all off" pattern
//   - Scan slot enumeration (which digit position is being driven)
// -----------------------------------------------------------------------------
package score_display_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

  localparam logic [AN_W-1:0]  ANODES_OFF = 4'b1111;

  // Slot value doubles as the anode bit index for the three digit slots.
  typedef enum logic [1:0] {
    SLOT_ONES     = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2,
    SLOT_IDLE     = 2'd3
  } slot_e;

endpackage : score_display_pkg

// File: rtl/score_display_scan_if.sv
// -----------------------------------------------------------------------------
// score_display_scan_if
// Bundle between the scoreboard side and the display scanner.
//   hundreds_digit/tens_digit/ones_digit : BCD digits from the scoreboard
//   blank                                : active-high, forces all anodes off
//   an  : anode enables, active-low (an[0]=ones, an[1]=tens, an[2]=hundreds)
//   seg : segments, active-low, {g,f,e,d,c,b,a}
//   dp  : decimal point, active-low, always off
// master = scoreboard / pin side, slave = scanner.
// -----------------------------------------------------------------------------
interface score_display_scan_if;
  import score_display_pkg::*;

  logic [DIGIT_W-1:0] hundreds_digit;
  logic [DIGIT_W-1:0] tens_digit;
  logic [DIGIT_W-1:0] ones_digit;
  logic               blank;
  logic [AN_W-1:0]    an;
  logic [SEG_W-1:0]   seg;
  logic               dp;

  modport master (
    output hundreds_digit, tens_digit, ones_digit, blank,
    input  an, seg, dp
  );

  modport slave (
    input  hundreds_digit, tens_digit, ones_digit, blank,
    output an, seg, dp
  );

endinterface : score_display_scan_if

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to active-low seven-segment decoder.
//   bcd_i : 4-bit digit; 10..15 are not BCD and render as a dash
//   seg_o : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import score_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  output logic [SEG_W-1:0]   seg_o
);

  always_comb begin
    // NOTE: the default arm covers every unlisted code, so seg_o is assigned
    // on every path and no latch is inferred.
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule : bcd_to_seg7

// File: rtl/score_display_scan.sv
// -----------------------------------------------------------------------------
// score_display_scan
// Time-multiplexes three BCD score digits onto a 4-digit common-anode
// seven-segment display. A shadow copy of the digits is taken once per scan
// frame (at the slot 3 -> slot 0 wrap) so a score change never tears a frame.
// Each slot starts with DEAD_CYCLES of all-anodes-off to suppress ghosting.
//
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   disp  : score_display_scan_if.slave (digits, blank in; an, seg, dp out)
//
// Parameters:
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
//   DEAD_CYCLES : leading blank cycles per slot (0 .. REFRESH_DIV-1)
//
// Optional build macro:
//   SCORE_DISPLAY_LZB_EN : leading-zero blanking of hundreds and tens.
// -----------------------------------------------------------------------------
module score_display_scan
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  score_display_scan_if.slave disp
);

  localparam int unsigned     PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]      prescaler_q, prescaler_d;
  slot_e              slot_q, slot_d;
  logic [DIGIT_W-1:0] sh_hund_q, sh_hund_d;
  logic [DIGIT_W-1:0] sh_tens_q, sh_tens_d;
  logic [DIGIT_W-1:0] sh_ones_q, sh_ones_d;
  logic [AN_W-1:0]    an_q, an_d;
  logic [SEG_W-1:0]   seg_q, seg_d;

  logic               tick;
  logic               in_dead;
  logic               show_tens;
  logic               show_hund;
  logic [DIGIT_W-1:0] digit_mux;
  logic [SEG_W-1:0]   seg_dec;

  assign tick = (prescaler_q == PRESC_LAST);

  // With no dead time the comparison would be constant, so it is not built.
  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (prescaler_q < PW'(DEAD_CYCLES));
  end

`ifdef SCORE_DISPLAY_LZB_EN
  assign show_hund = (sh_hund_q != '0);
  assign show_tens = (sh_hund_q != '0) || (sh_tens_q != '0);
`else
  assign show_hund = 1'b1;
  assign show_tens = 1'b1;
`endif

  bcd_to_seg7 u_dec (
    .bcd_i (digit_mux),
    .seg_o (seg_dec)
  );

  // Next-state and registered-output logic.
  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    slot_d      = slot_q;
    sh_hund_d   = sh_hund_q;
    sh_tens_d   = sh_tens_q;
    sh_ones_d   = sh_ones_q;
    digit_mux   = '0;
    an_d        = ANODES_OFF;
    seg_d       = SEG_OFF;

    if (tick) begin
      unique case (slot_q)
        SLOT_ONES:     slot_d = SLOT_TENS;
        SLOT_TENS:     slot_d = SLOT_HUNDREDS;
        SLOT_HUNDREDS: slot_d = SLOT_IDLE;
        default: begin
          // Frame wrap: the only moment the scoreboard digits are sampled.
          slot_d    = SLOT_ONES;
          sh_hund_d = disp.hundreds_digit;
          sh_tens_d = disp.tens_digit;
          sh_ones_d = disp.ones_digit;
        end
      endcase
    end

    // Segments follow the slot even during dead time; only anodes are gated.
    unique case (slot_q)
      SLOT_ONES: begin
        digit_mux = sh_ones_q;
        seg_d     = seg_dec;
        an_d      = 4'b1110;
      end
      SLOT_TENS: begin
        digit_mux = sh_tens_q;
        seg_d     = seg_dec;
        if (show_tens) an_d = 4'b1101;
      end
      SLOT_HUNDREDS: begin
        digit_mux = sh_hund_q;
        seg_d     = seg_dec;
        if (show_hund) an_d = 4'b1011;
      end
      default: begin
        digit_mux = '0;
        seg_d     = SEG_OFF;
        an_d      = ANODES_OFF;
      end
    endcase

    if (in_dead || disp.blank) an_d = ANODES_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      slot_q      <= SLOT_ONES;
      sh_hund_q   <= '0;
      sh_tens_q   <= '0;
      sh_ones_q   <= '0;
      an_q        <= ANODES_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      prescaler_q <= prescaler_d;
      slot_q      <= slot_d;
      sh_hund_q   <= sh_hund_d;
      sh_tens_q   <= sh_tens_d;
      sh_ones_q   <= sh_ones_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = 1'b1;

endmodule : score_display_scan

// File: tb/tb_score_display_scan.sv
// -----------------------------------------------------------------------------
// tb_score_display_scan
// Self-checking bench. dut_a runs REFRESH_DIV=4/DEAD_CYCLES=1 through directed
// and random phases; dut_b runs REFRESH_DIV=2/DEAD_CYCLES=0 with random inputs
// and reset pulses. A cycle-count based reference model predicts an/seg.
// Honours SCORE_DISPLAY_LZB_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_score_display_scan;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  always #5 clk = ~clk;

  score_display_scan_if if_a ();
  score_display_scan_if if_b ();

  score_display_scan #(.REFRESH_DIV(4), .DEAD_CYCLES(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .disp  (if_a.slave)
  );

  score_display_scan #(.REFRESH_DIV(2), .DEAD_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .disp  (if_b.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int unsigned cfg_div  = 4;
  int unsigned cfg_dead = 1;
  int unsigned m_t      = 0;          // cycles since reset release
  logic [3:0]  m_sh [3];              // 0=ones, 1=tens, 2=hundreds

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    int idx;
    idx = int'(d);
    if (idx > 9) return 7'b0111111;
    return SEG_TAB[idx];
  endfunction

  // One clock: predict from pre-edge state/inputs, advance model, compare.
  task automatic step(input bit sel_b);
    logic [3:0] h, tn, o, exp_an, got_an, onehot;
    logic [6:0] exp_seg, got_seg;
    logic       bl, rn, got_dp, lit;
    int unsigned p, s;

    if (sel_b) begin
      h = if_b.hundreds_digit; tn = if_b.tens_digit; o = if_b.ones_digit;
      bl = if_b.blank; rn = rst_b_n;
    end else begin
      h = if_a.hundreds_digit; tn = if_a.tens_digit; o = if_a.ones_digit;
      bl = if_a.blank; rn = rst_a_n;
    end

    if (!rn) begin
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      m_t     = 0;
      m_sh[0] = '0; m_sh[1] = '0; m_sh[2] = '0;
    end else begin
      p = m_t % cfg_div;
      s = (m_t / cfg_div) % 4;
      exp_seg = (s == 3) ? 7'b1111111 : ref_seg(m_sh[s]);
      lit = (s < 3) && !bl && (p >= cfg_dead);
`ifdef SCORE_DISPLAY_LZB_EN
      if (s == 2 && m_sh[2] == 4'd0) lit = 1'b0;
      if (s == 1 && m_sh[2] == 4'd0 && m_sh[1] == 4'd0) lit = 1'b0;
`endif
      onehot = 4'b0001 << s;
      exp_an = lit ? ~onehot : 4'b1111;
      if (p == cfg_div - 1 && s == 3) begin
        m_sh[0] = o; m_sh[1] = tn; m_sh[2] = h;
      end
      m_t++;
    end

    @(posedge clk);
    #1;
    if (sel_b) begin
      got_an = if_b.an; got_seg = if_b.seg; got_dp = if_b.dp;
    end else begin
      got_an = if_a.an; got_seg = if_a.seg; got_dp = if_a.dp;
    end
    check(sel_b ? "b_an" : "a_an", 32'(got_an), 32'(exp_an));
    check(sel_b ? "b_seg" : "a_seg", 32'(got_seg), 32'(exp_seg));
    check(sel_b ? "b_dp" : "a_dp", 32'(got_dp), 32'd1);
    check(sel_b ? "b_one_anode" : "a_one_anode", 32'($countones(~got_an) <= 1), 32'd1);
  endtask

  task automatic set_a(input logic [3:0] h, input logic [3:0] tn, input logic [3:0] o);
    if_a.hundreds_digit = h; if_a.tens_digit = tn; if_a.ones_digit = o;
  endtask

  task automatic run_a(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    set_a(4'd1, 4'd2, 4'd3);
    if_a.blank = 1'b0;
    if_b.hundreds_digit = '0; if_b.tens_digit = '0; if_b.ones_digit = '0;
    if_b.blank = 1'b0;
    #2;

    // 1. Reset held 3 cycles, then first frame shows the zeroed shadow.
    rst_a_n = 1'b0;
    run_a(3);
    rst_a_n = 1'b1;

    // 2. Inputs 123 across two frames (frame = 16 cycles).
    run_a(32);

    // 3. Change to 456 mid slot 1 of the current frame.
    run_a(6);
    set_a(4'd4, 4'd5, 4'd6);
    run_a(10 + 16);

    // 4. Illegal tens digit, then blank pulse mid-slot.
    set_a(4'd4, 4'hC, 4'd6);
    run_a(16 + 6);
    if_a.blank = 1'b1;
    run_a(7);
    if_a.blank = 1'b0;
    run_a(20);

    // 5. Leading-zero patterns.
    set_a(4'd0, 4'd0, 4'd7);
    run_a(32);
    set_a(4'd0, 4'd7, 4'd0);
    run_a(32);

    // Reset mid-slot, then random digits and blanking.
    run_a(5);
    rst_a_n = 1'b0;
    run_a(1);
    rst_a_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_a(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if_a.blank = ($urandom_range(0, 9) == 0);
      step(1'b0);
    end

    // 6. dut_b: fast scan, random inputs and reset pulses.
    cfg_div  = 2;
    cfg_dead = 0;
    rst_b_n  = 1'b0;
    step(1'b1);
    for (int i = 0; i < 2000; i++) begin
      rst_b_n = ($urandom_range(0, 49) != 0);
      if_b.blank = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if_b.hundreds_digit = 4'($urandom_range(0, 15));
        if_b.tens_digit     = 4'($urandom_range(0, 15));
        if_b.ones_digit     = 4'($urandom_range(0, 15));
      end
      step(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_score_display_scan
